// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use bubble insertion, WB bypass
//            folding and a saturating load-use stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_useRs1,
   input  logic             id_useRs2,
   input  logic             id_ctrl_regWrite,
   input  logic             id_ctrl_toReg,
   input  logic             id_ctrl_memWrite,
   input  logic [3:0]       id_ctrl_aluOp,
   input  logic [XLEN-1:0]  id_regRData1,
   input  logic [XLEN-1:0]  id_regRData2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [XLEN-1:0]  id_pc,
   input  logic             mem_wb_rw,
   input  logic [4:0]       mem_wb_rd,
   input  logic [XLEN-1:0]  mem_wb_wdata,
   input  logic             ex_flush,
   input  logic             ex_stall,
   output logic             id_ex_valid,
   output logic [4:0]       id_ex_rs1,
   output logic [4:0]       id_ex_rs2,
   output logic [4:0]       id_ex_rd,
   output logic             id_ex_ctrl_regWrite,
   output logic             id_ex_ctrl_toReg,
   output logic             id_ex_ctrl_memWrite,
   output logic [3:0]       id_ex_ctrl_aluOp,
   output logic [XLEN-1:0]  id_ex_data_regRData1,
   output logic [XLEN-1:0]  id_ex_data_regRData2,
   output logic [XLEN-1:0]  id_ex_imm,
   output logic [XLEN-1:0]  id_ex_pc,
   output logic             stall_out,
   output logic [CNT_W-1:0] loaduse_cnt
);

   logic             valid_q, valid_d;
   logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic             regwrite_q, regwrite_d;
   logic             toreg_q, toreg_d;
   logic             memwrite_q, memwrite_d;
   logic [3:0]       aluop_q, aluop_d;
   logic [XLEN-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;
   logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             wb_wr_nz;
   logic             rs1_dep, rs2_dep;
   logic             hazard;
   logic             bubble;

   assign wb_wr_nz = mem_wb_rw & (mem_wb_rd != 5'd0);

   assign rs1_dep  = id_useRs1 & (id_rs1 == rd_q);
   assign rs2_dep  = id_useRs2 & (id_rs2 == rd_q);
   assign hazard   = id_valid & valid_q & toreg_q & regwrite_q & (rd_q != 5'd0)
                   & (rs1_dep | rs2_dep);

   assign stall_out = ex_stall | (hazard & ~ex_flush);

   // Flush always wins; a hazard only bubbles when the back end is moving.
   assign bubble   = ex_flush | (~ex_stall & hazard);

   always_comb begin
      valid_d    = valid_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      regwrite_d = regwrite_q;
      toreg_d    = toreg_q;
      memwrite_d = memwrite_q;
      aluop_d    = aluop_q;
      rdata1_d   = rdata1_q;
      rdata2_d   = rdata2_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;

      if (bubble) begin
         valid_d    = 1'b0;
         rs1_d      = 5'd0;
         rs2_d      = 5'd0;
         rd_d       = 5'd0;
         regwrite_d = 1'b0;
         toreg_d    = 1'b0;
         memwrite_d = 1'b0;
         aluop_d    = 4'd0;
         rdata1_d   = '0;
         rdata2_d   = '0;
         imm_d      = '0;
         pc_d       = '0;
         if (!ex_flush && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (ex_stall) begin
         // Held operands must still see the write WB retires this cycle.
         if (wb_wr_nz && mem_wb_rd == rs1_q) begin
            rdata1_d = mem_wb_wdata;
         end
         if (wb_wr_nz && mem_wb_rd == rs2_q) begin
            rdata2_d = mem_wb_wdata;
         end
      end else begin
         valid_d    = id_valid;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         regwrite_d = id_ctrl_regWrite & id_valid;
         toreg_d    = id_ctrl_toReg & id_valid;
         memwrite_d = id_ctrl_memWrite & id_valid;
         aluop_d    = id_ctrl_aluOp;
         rdata1_d   = (wb_wr_nz && mem_wb_rd == id_rs1) ? mem_wb_wdata : id_regRData1;
         rdata2_d   = (wb_wr_nz && mem_wb_rd == id_rs2) ? mem_wb_wdata : id_regRData2;
         imm_d      = id_imm;
         pc_d       = id_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rd_q       <= 5'd0;
         regwrite_q <= 1'b0;
         toreg_q    <= 1'b0;
         memwrite_q <= 1'b0;
         aluop_q    <= 4'd0;
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         toreg_q    <= toreg_d;
         memwrite_q <= memwrite_d;
         aluop_q    <= aluop_d;
         rdata1_q   <= rdata1_d;
         rdata2_q   <= rdata2_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
      end
   end

   assign id_ex_valid          = valid_q;
   assign id_ex_rs1            = rs1_q;
   assign id_ex_rs2            = rs2_q;
   assign id_ex_rd             = rd_q;
   assign id_ex_ctrl_regWrite  = regwrite_q;
   assign id_ex_ctrl_toReg     = toreg_q;
   assign id_ex_ctrl_memWrite  = memwrite_q;
   assign id_ex_ctrl_aluOp     = aluop_q;
   assign id_ex_data_regRData1 = rdata1_q;
   assign id_ex_data_regRData2 = rdata2_q;
   assign id_ex_imm            = imm_q;
   assign id_ex_pc             = pc_q;
   assign loaduse_cnt          = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Self-checking bench for id_ex_stage against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid, id_useRs1, id_useRs2;
   logic [4:0]       id_rs1, id_rs2, id_rd, mem_wb_rd;
   logic             id_ctrl_regWrite, id_ctrl_toReg, id_ctrl_memWrite;
   logic [3:0]       id_ctrl_aluOp;
   logic [XLEN-1:0]  id_regRData1, id_regRData2, id_imm, id_pc, mem_wb_wdata;
   logic             mem_wb_rw, ex_flush, ex_stall;
   logic             id_ex_valid, id_ex_ctrl_regWrite, id_ex_ctrl_toReg, id_ex_ctrl_memWrite;
   logic [4:0]       id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [3:0]       id_ex_ctrl_aluOp;
   logic [XLEN-1:0]  id_ex_data_regRData1, id_ex_data_regRData2, id_ex_imm, id_ex_pc;
   logic             stall_out;
   logic [CNT_W-1:0] loaduse_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
      .id_ctrl_regWrite(id_ctrl_regWrite), .id_ctrl_toReg(id_ctrl_toReg),
      .id_ctrl_memWrite(id_ctrl_memWrite), .id_ctrl_aluOp(id_ctrl_aluOp),
      .id_regRData1(id_regRData1), .id_regRData2(id_regRData2),
      .id_imm(id_imm), .id_pc(id_pc),
      .mem_wb_rw(mem_wb_rw), .mem_wb_rd(mem_wb_rd), .mem_wb_wdata(mem_wb_wdata),
      .ex_flush(ex_flush), .ex_stall(ex_stall),
      .id_ex_valid(id_ex_valid), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
      .id_ex_rd(id_ex_rd), .id_ex_ctrl_regWrite(id_ex_ctrl_regWrite),
      .id_ex_ctrl_toReg(id_ex_ctrl_toReg), .id_ex_ctrl_memWrite(id_ex_ctrl_memWrite),
      .id_ex_ctrl_aluOp(id_ex_ctrl_aluOp),
      .id_ex_data_regRData1(id_ex_data_regRData1),
      .id_ex_data_regRData2(id_ex_data_regRData2),
      .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc),
      .stall_out(stall_out), .loaduse_cnt(loaduse_cnt)
   );

   typedef struct packed {
      bit        valid;
      bit [4:0]  rs1, rs2, rd;
      bit        rw, tr, mw;
      bit [3:0]  op;
      bit [31:0] d1, d2, imm, pc;
      int        cnt;
   } ex_t;

   ex_t m;
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // The EX instruction is a real load writing a nonzero register that ID reads.
   function automatic bit model_hazard();
      bit reads_it;
      reads_it = (id_useRs1 && id_rs1 == m.rd) || (id_useRs2 && id_rs2 == m.rd);
      return id_valid && m.valid && m.tr && m.rw && m.rd != 0 && reads_it;
   endfunction

   function automatic bit [31:0] wb_value(input bit [4:0] r, input bit [31:0] rf);
      if (mem_wb_rw && mem_wb_rd != 0 && mem_wb_rd == r) return mem_wb_wdata;
      return rf;
   endfunction

   // Apply the current inputs across one clock edge and compare against the model.
   task automatic step();
      ex_t n;
      bit  hz;
      #2;
      hz = model_hazard();
      chk("stall_out", {63'd0, stall_out}, {63'd0, (ex_stall || (hz && !ex_flush))});
      n = m;
      if (rst) begin
         n = '0;
      end else if (ex_flush || (!ex_stall && hz)) begin
         n.valid = 0; n.rw = 0; n.tr = 0; n.mw = 0;
         if (!ex_flush) n.cnt = (m.cnt >= CMAX) ? CMAX : m.cnt + 1;
      end else if (ex_stall) begin
         n.d1 = wb_value(m.rs1, m.d1);
         n.d2 = wb_value(m.rs2, m.d2);
      end else begin
         n.valid = id_valid;
         n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
         n.rw = id_valid && id_ctrl_regWrite;
         n.tr = id_valid && id_ctrl_toReg;
         n.mw = id_valid && id_ctrl_memWrite;
         n.op = id_ctrl_aluOp;
         n.d1 = wb_value(id_rs1, id_regRData1);
         n.d2 = wb_value(id_rs2, id_regRData2);
         n.imm = id_imm; n.pc = id_pc;
      end
      @(posedge clk);
      #1;
      m = n;
      chk("valid",    {63'd0, id_ex_valid},         {63'd0, m.valid});
      chk("regWrite", {63'd0, id_ex_ctrl_regWrite}, {63'd0, m.rw});
      chk("toReg",    {63'd0, id_ex_ctrl_toReg},    {63'd0, m.tr});
      chk("memWrite", {63'd0, id_ex_ctrl_memWrite}, {63'd0, m.mw});
      chk("loaduse_cnt", {60'd0, loaduse_cnt}, 64'(m.cnt));
      if (m.valid) begin
         chk("rs1",   {59'd0, id_ex_rs1},        {59'd0, m.rs1});
         chk("rs2",   {59'd0, id_ex_rs2},        {59'd0, m.rs2});
         chk("rd",    {59'd0, id_ex_rd},         {59'd0, m.rd});
         chk("aluOp", {60'd0, id_ex_ctrl_aluOp}, {60'd0, m.op});
         chk("rdata1", {32'd0, id_ex_data_regRData1}, {32'd0, m.d1});
         chk("rdata2", {32'd0, id_ex_data_regRData2}, {32'd0, m.d2});
         chk("imm",   {32'd0, id_ex_imm}, {32'd0, m.imm});
         chk("pc",    {32'd0, id_ex_pc},  {32'd0, m.pc});
      end
   endtask

   task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                         input bit u1, input bit u2, input bit rw, input bit tr, input bit mw);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_useRs1 = u1; id_useRs2 = u2;
      id_ctrl_regWrite = rw; id_ctrl_toReg = tr; id_ctrl_memWrite = mw;
   endtask

   task automatic quiet();
      rst = 0; ex_flush = 0; ex_stall = 0; mem_wb_rw = 0; mem_wb_rd = 0; mem_wb_wdata = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, {63'd0, id_ex_valid}, 64'd0);
      chk({tag, "_fields"}, {44'd0, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl_aluOp,
                             id_ex_ctrl_regWrite, id_ex_ctrl_toReg, id_ex_ctrl_memWrite}, 64'd0);
      chk({tag, "_data"}, {id_ex_data_regRData1 | id_ex_data_regRData2,
                           id_ex_imm | id_ex_pc}, 64'd0);
      chk({tag, "_cnt"}, {60'd0, loaduse_cnt}, 64'd0);
   endtask

   initial begin
      m = '0;
      quiet();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      id_ctrl_aluOp = 0; id_regRData1 = 0; id_regRData2 = 0; id_imm = 0; id_pc = 0;
      @(posedge clk); #1;
      rst = 1;
      step();
      check_all_zero("reset");
      quiet();

      // Back-to-back ALU ops never stall
      set_id(1, 1, 2, 5, 1, 1, 1, 0, 0); id_pc = 32'h100;
      step();
      set_id(1, 5, 0, 6, 1, 0, 1, 0, 0); id_pc = 32'h104;
      step();
      chk("alu_b2b_valid", {63'd0, id_ex_valid}, 64'd1);
      chk("alu_b2b_cnt", {60'd0, loaduse_cnt}, 64'd0);

      // Load-use: one bubble, then the dependent instruction captures
      set_id(1, 1, 0, 7, 1, 0, 1, 1, 0);
      step();
      set_id(1, 3, 7, 8, 1, 1, 1, 0, 0);
      #2 chk("lu_stall", {63'd0, stall_out}, 64'd1);
      step();
      chk("lu_bubble", {63'd0, id_ex_valid}, 64'd0);
      chk("lu_cnt", {60'd0, loaduse_cnt}, 64'd1);
      #2 chk("lu_release", {63'd0, stall_out}, 64'd0);
      step();
      chk("lu_capture", {58'd0, id_ex_valid, id_ex_rs2}, {58'd0, 1'b1, 5'd7});

      // Load to x0 never stalls
      set_id(1, 1, 0, 0, 1, 0, 1, 1, 0);
      step();
      set_id(1, 0, 0, 9, 1, 0, 1, 0, 0);
      #2 chk("x0_nostall", {63'd0, stall_out}, 64'd0);
      step();
      chk("x0_valid", {63'd0, id_ex_valid}, 64'd1);

      // WB bypass, and no bypass of x0
      set_id(1, 3, 4, 10, 1, 1, 1, 0, 0);
      id_regRData1 = 32'h11; id_regRData2 = 32'h22;
      mem_wb_rw = 1; mem_wb_rd = 3; mem_wb_wdata = 32'hDEADBEEF;
      step();
      chk("bypass_hit", {32'd0, id_ex_data_regRData1}, 64'hDEADBEEF);
      mem_wb_rd = 0;
      step();
      chk("bypass_x0", {32'd0, id_ex_data_regRData1}, 64'h11);
      quiet();

      // Hold-refresh under a 3-cycle stall
      set_id(1, 2, 9, 4, 1, 1, 1, 0, 0);
      id_regRData2 = 32'hAAAA; id_imm = 32'h55; id_ctrl_aluOp = 4'h3;
      step();
      set_id(1, 12, 13, 14, 1, 1, 1, 0, 1);
      id_regRData2 = 32'hBAD; id_imm = 32'hBAD; id_ctrl_aluOp = 4'hF;
      ex_stall = 1;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin mem_wb_rw = 1; mem_wb_rd = 9; mem_wb_wdata = 32'h1234; end
         else mem_wb_rw = 0;
         #2 chk("hold_stall", {63'd0, stall_out}, 64'd1);
         step();
         chk("hold_rd", {59'd0, id_ex_rd}, 64'd4);
         chk("hold_rdata2", {32'd0, id_ex_data_regRData2}, (c == 0) ? 64'hAAAA : 64'h1234);
      end
      quiet();

      // Flush beats hazard and stall; count unchanged
      set_id(1, 1, 0, 7, 1, 0, 1, 1, 0);
      step();
      set_id(1, 0, 7, 8, 0, 1, 1, 0, 0);
      ex_flush = 1; ex_stall = 1;
      #2 chk("flush_stall_out", {63'd0, stall_out}, 64'd1);
      step();
      chk("flush_bubble", {63'd0, id_ex_valid}, 64'd0);
      chk("flush_cnt", {60'd0, loaduse_cnt}, 64'd1);
      quiet();

      // Chain of dependent loads drives the counter into saturation
      set_id(1, 7, 0, 7, 1, 0, 1, 1, 0);
      for (int i = 0; i < 2 * CMAX + 6; i++) step();
      chk("cnt_saturated", {60'd0, loaduse_cnt}, CMAX);

      // Mid-run reset while holding a valid instruction
      set_id(1, 2, 3, 4, 1, 1, 1, 0, 0);
      step();
      ex_stall = 1; rst = 1;
      step();
      check_all_zero("midrst");
      quiet();

      // Random traffic over a small register set to provoke dependencies
      for (int i = 0; i < 3000; i++) begin
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
         id_ctrl_aluOp = 4'($urandom);
         id_regRData1 = $urandom; id_regRData2 = $urandom;
         id_imm = $urandom; id_pc = $urandom;
         mem_wb_rw = $urandom_range(0, 1) == 1;
         mem_wb_rd = 5'($urandom_range(0, 3));
         mem_wb_wdata = $urandom;
         ex_flush = $urandom_range(0, 9) == 0;
         ex_stall = $urandom_range(0, 4) == 0;
         rst = $urandom_range(0, 99) == 0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire
